// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IFU and LSU share one memory port.
// One transaction outstanding; LSU favoured up to a bounded streak.
module mem_arbiter #(
   parameter int unsigned MAX_LSU_STREAK = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ifu_req,
   input  logic [31:0] i_ifu_addr,
   output logic        o_ifu_gnt,
   output logic        o_ifu_rvalid,
   output logic [31:0] o_ifu_rdata,
   input  logic        i_lsu_req,
   input  logic        i_lsu_wen,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_lsu_wdata,
   input  logic [3:0]  i_lsu_wmask,
   output logic        o_lsu_gnt,
   output logic        o_lsu_rvalid,
   output logic [31:0] o_lsu_rdata,
   output logic        o_mem_req,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wmask,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy,
   output logic        o_err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } state_t;

   state_t      state;
   logic        owner_lsu;
   logic [3:0]  streak;
   logic        err;
   logic        sel_lsu;
   logic        in_req;
   logic        in_resp;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

   // LSU wins a tie unless it has already starved the IFU long enough
   assign sel_lsu = i_lsu_req &
                    (~i_ifu_req | (streak != STREAK_MAX));

   // State, owner, starvation streak and sticky protocol error
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         owner_lsu <= 1'b0;
         streak    <= 4'd0;
         err       <= 1'b0;
      end else begin
         if (i_mem_rvalid && state != RESP)
            err <= 1'b1;
         case (state)
            IDLE: begin
               if (i_ifu_req | i_lsu_req) begin
                  owner_lsu <= sel_lsu;
                  state     <= REQ;
                  if (!sel_lsu)
                     streak <= 4'd0;
                  else if (i_ifu_req && streak != 4'hF)
                     streak <= streak + 4'd1;
               end
            end
            REQ: begin
               if (i_mem_gnt)
                  state <= RESP;
            end
            RESP: begin
               if (i_mem_rvalid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_req  = (state == REQ);
   assign in_resp = (state == RESP);

   // Memory port follows the latched owner's live inputs
   assign o_mem_req   = in_req;
   assign o_mem_addr  = owner_lsu ? i_lsu_addr : i_ifu_addr;
   assign o_mem_wen   = owner_lsu & i_lsu_wen;
   assign o_mem_wdata = owner_lsu ? i_lsu_wdata : 32'd0;
   assign o_mem_wmask = owner_lsu ? i_lsu_wmask : 4'd0;

   assign o_ifu_gnt    = in_req & ~owner_lsu & i_mem_gnt;
   assign o_lsu_gnt    = in_req & owner_lsu & i_mem_gnt;
   assign o_ifu_rvalid = in_resp & ~owner_lsu & i_mem_rvalid;
   assign o_lsu_rvalid = in_resp & owner_lsu & i_mem_rvalid;

   assign o_ifu_rdata = i_mem_rdata;
   assign o_lsu_rdata = i_mem_rdata;

   assign o_busy = (state != IDLE);
   assign o_err  = err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs driven at falling edge; outputs sampled 1ns later.
module tb_mem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_ifu_req;
   logic [31:0] i_ifu_addr;
   logic        o_ifu_gnt;
   logic        o_ifu_rvalid;
   logic [31:0] o_ifu_rdata;
   logic        i_lsu_req;
   logic        i_lsu_wen;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_lsu_wdata;
   logic [3:0]  i_lsu_wmask;
   logic        o_lsu_gnt;
   logic        o_lsu_rvalid;
   logic [31:0] o_lsu_rdata;
   logic        o_mem_req;
   logic        o_mem_wen;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_wmask;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_busy;
   logic        o_err;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   mem_arbiter #(.MAX_LSU_STREAK(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_ifu_req(i_ifu_req), .i_ifu_addr(i_ifu_addr),
      .o_ifu_gnt(o_ifu_gnt), .o_ifu_rvalid(o_ifu_rvalid),
      .o_ifu_rdata(o_ifu_rdata),
      .i_lsu_req(i_lsu_req), .i_lsu_wen(i_lsu_wen),
      .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
      .i_lsu_wmask(i_lsu_wmask),
      .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid),
      .o_lsu_rdata(o_lsu_rdata),
      .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_wmask(o_mem_wmask),
      .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy), .o_err(o_err)
   );

   task automatic clear_inputs();
      i_ifu_req    = 1'b0;
      i_ifu_addr   = 32'd0;
      i_lsu_req    = 1'b0;
      i_lsu_wen    = 1'b0;
      i_lsu_addr   = 32'd0;
      i_lsu_wdata  = 32'd0;
      i_lsu_wmask  = 4'd0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'd0;
   endtask

   task automatic pulse_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      i_rst = 1'b1;
      i_ifu_req = 1'b1;
      i_lsu_req = 1'b1;
      repeat (3) @(negedge i_clk);
      i_ifu_req = 1'b0;
      i_lsu_req = 1'b0;
      i_rst = 1'b0;
      #1;
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %0b exp 0", o_busy);
      end
      checks++;
      if (o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_mem_req got %0b exp 0", o_mem_req);
      end
      checks++;
      if ({o_ifu_gnt, o_lsu_gnt, o_ifu_rvalid, o_lsu_rvalid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_handshake got %b exp 0000",
                  {o_ifu_gnt, o_lsu_gnt, o_ifu_rvalid, o_lsu_rvalid});
      end
      checks++;
      if (o_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %0b exp 0", o_err);
      end
   endtask

   task automatic test_ifu_single();
      @(negedge i_clk);
      i_ifu_req  = 1'b1;
      i_ifu_addr = 32'h8000_0000;
      i_mem_gnt  = 1'b1;
      #1;
      checks++;
      if (o_ifu_gnt !== 1'b0 || o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL ifu_t0 gnt=%0b req=%0b exp 0 0", o_ifu_gnt, o_mem_req);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (o_ifu_gnt !== 1'b1 || o_lsu_gnt !== 1'b0) begin
         errors++;
         $display("FAIL ifu_t1_gnt ifu=%0b lsu=%0b exp 1 0", o_ifu_gnt, o_lsu_gnt);
      end
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h8000_0000 ||
          o_mem_wen !== 1'b0 || o_mem_wdata !== 32'd0 || o_mem_wmask !== 4'd0) begin
         errors++;
         $display("FAIL ifu_t1_mem req=%0b addr=%h wen=%0b wd=%h wm=%h exp 1 80000000 0 0 0",
                  o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask);
      end
      @(negedge i_clk);
      i_ifu_req    = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h0000_0413;
      #1;
      checks++;
      if (o_ifu_rvalid !== 1'b1 || o_ifu_rdata !== 32'h0000_0413) begin
         errors++;
         $display("FAIL ifu_t2_rvalid rv=%0b rd=%h exp 1 00000413", o_ifu_rvalid, o_ifu_rdata);
      end
      checks++;
      if (o_mem_req !== 1'b0 || o_lsu_rvalid !== 1'b0 || o_ifu_gnt !== 1'b0) begin
         errors++;
         $display("FAIL ifu_t2_quiet req=%0b lrv=%0b ig=%0b exp 0 0 0",
                  o_mem_req, o_lsu_rvalid, o_ifu_gnt);
      end
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'd0;
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL ifu_t3 busy=%0b err=%0b exp 0 0", o_busy, o_err);
      end
   endtask

   task automatic test_lsu_write_stall();
      @(negedge i_clk);
      i_lsu_req   = 1'b1;
      i_lsu_wen   = 1'b1;
      i_lsu_addr  = 32'h8000_1000;
      i_lsu_wdata = 32'hDEAD_BEEF;
      i_lsu_wmask = 4'hF;
      i_mem_gnt   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         i_mem_gnt = (c == 3);
         #1;
         checks++;
         if (o_mem_req !== 1'b1 || o_mem_wen !== 1'b1 ||
             o_mem_addr !== 32'h8000_1000 || o_mem_wdata !== 32'hDEAD_BEEF ||
             o_mem_wmask !== 4'hF) begin
            errors++;
            $display("FAIL lsu_req_c%0d req=%0b wen=%0b a=%h d=%h m=%h exp 1 1 80001000 deadbeef f",
                     c, o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask);
         end
         checks++;
         if (o_lsu_gnt !== (c == 3) || o_ifu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lsu_gnt_c%0d lsu=%0b ifu=%0b exp %0b 0",
                     c, o_lsu_gnt, o_ifu_gnt, (c == 3));
         end
      end
      @(negedge i_clk);
      i_lsu_req    = 1'b0;
      i_lsu_wen    = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b1;
      #1;
      checks++;
      if (o_lsu_rvalid !== 1'b1 || o_ifu_rvalid !== 1'b0 || o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL lsu_ack lrv=%0b irv=%0b req=%0b exp 1 0 0",
                  o_lsu_rvalid, o_ifu_rvalid, o_mem_req);
      end
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL lsu_done busy=%0b err=%0b exp 0 0", o_busy, o_err);
      end
   endtask

   task automatic test_err_idle();
      @(negedge i_clk);
      i_mem_rvalid = 1'b1;
      #1;
      checks++;
      if (o_ifu_rvalid !== 1'b0 || o_lsu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL err_rvalid irv=%0b lrv=%0b exp 0 0", o_ifu_rvalid, o_lsu_rvalid);
      end
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      #1;
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL err_set err=%0b busy=%0b exp 1 0", o_err, o_busy);
      end
      repeat (3) @(negedge i_clk);
      #1;
      checks++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got %0b exp 1", o_err);
      end
      pulse_reset();
      #1;
      checks++;
      if (o_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear got %0b exp 0", o_err);
      end
   endtask

   task automatic test_reset_in_resp();
      @(negedge i_clk);
      i_ifu_req  = 1'b1;
      i_ifu_addr = 32'h8000_0040;
      i_mem_gnt  = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_ifu_req = 1'b0;
      i_mem_gnt = 1'b0;
      i_rst     = 1'b1;
      #1;
      checks++;
      if (o_busy !== 1'b1 || o_mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_resp_pre busy=%0b req=%0b exp 1 0", o_busy, o_mem_req);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      checks++;
      if ({o_busy, o_mem_req, o_ifu_gnt, o_lsu_gnt,
           o_ifu_rvalid, o_lsu_rvalid, o_err} !== 7'b0) begin
         errors++;
         $display("FAIL rst_resp_idle outs=%b exp 0000000",
                  {o_busy, o_mem_req, o_ifu_gnt, o_lsu_gnt,
                   o_ifu_rvalid, o_lsu_rvalid, o_err});
      end
      @(negedge i_clk);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h1234_5678;
      #1;
      checks++;
      if (o_ifu_rvalid !== 1'b0 || o_lsu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_rvalid irv=%0b lrv=%0b exp 0 0", o_ifu_rvalid, o_lsu_rvalid);
      end
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      #1;
      checks++;
      if (o_err !== 1'b1) begin
         errors++;
         $display("FAIL rst_late_err got %0b exp 1", o_err);
      end
      pulse_reset();
   endtask

   task automatic test_ifu_only();
      int n_gnt;
      int w;
      logic granted;
      logic lsu_seen;
      n_gnt = 0;
      lsu_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         i_mem_rvalid = 1'b0;
         i_ifu_req    = 1'b1;
         i_ifu_addr   = 32'h8000_0000 + 32'(i * 4);
         i_mem_gnt    = 1'b0;
         granted = 1'b0;
         w = 0;
         while (!granted && w < 10) begin
            @(negedge i_clk);
            i_mem_gnt = (w >= (i % 3));
            #1;
            granted = o_ifu_gnt;
            if (o_lsu_gnt) lsu_seen = 1'b1;
            w++;
         end
         checks++;
         if (!granted || o_mem_addr !== i_ifu_addr) begin
            errors++;
            $display("FAIL ifu_only_gnt%0d granted=%0b addr=%h exp 1 %h",
                     i, granted, o_mem_addr, i_ifu_addr);
         end
         if (granted) n_gnt++;
         @(negedge i_clk);
         i_ifu_req    = 1'b0;
         i_mem_gnt    = 1'b0;
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = 32'(i);
      end
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      #1;
      checks++;
      if (n_gnt != 20 || lsu_seen || o_err !== 1'b0) begin
         errors++;
         $display("FAIL ifu_only_total gnts=%0d lsu=%0b err=%0b exp 20 0 0",
                  n_gnt, lsu_seen, o_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] got;
      logic [9:0] want;
      logic       pend;
      int n;
      int cyc;
      int last_gnt;
      logic spacing_ok;
      want = 10'b0111101111;
      got = '0;
      pend = 1'b0;
      n = 0;
      cyc = 0;
      last_gnt = -10;
      spacing_ok = 1'b1;
      i_ifu_addr  = 32'h8000_0100;
      i_lsu_addr  = 32'h8000_2000;
      i_lsu_wen   = 1'b0;
      i_lsu_wmask = 4'd0;
      while (n < 10 && cyc < 60) begin
         @(negedge i_clk);
         i_ifu_req    = 1'b1;
         i_lsu_req    = 1'b1;
         i_mem_gnt    = 1'b1;
         i_mem_rvalid = pend;
         #1;
         pend = o_mem_req;
         if (o_ifu_gnt || o_lsu_gnt) begin
            if (cyc - last_gnt < 3) spacing_ok = 1'b0;
            last_gnt = cyc;
            got[n] = o_lsu_gnt;
            n++;
         end
         cyc++;
      end
      @(negedge i_clk);
      i_ifu_req    = 1'b0;
      i_lsu_req    = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = pend;
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      #1;
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL b2b_timeout grants=%0d exp 10", n);
      end
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL b2b_order got %b exp %b (bit0 first, 1=lsu)", got, want);
      end
      checks++;
      if (!spacing_ok || o_err !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_spacing ok=%0b err=%0b busy=%0b exp 1 0 0",
                  spacing_ok, o_err, o_busy);
      end
   endtask

   initial begin
      test_reset();
      test_ifu_single();
      test_lsu_write_stall();
      test_err_idle();
      test_reset_in_resp();
      test_ifu_only();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_LSU_STREAK, default 4; maximum consecutive LSU grants while IFU waits. SHALL be in 1..15.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_ifu_req  input  1  IFU read request; held with i_ifu_addr stable until o_ifu_gnt.
REQ-005 i_ifu_addr  input  32  IFU fetch address.
REQ-006 o_ifu_gnt / o_ifu_rvalid  output  1 each  IFU request accepted / IFU read data valid.
REQ-007 o_ifu_rdata  output  32  IFU read data.
REQ-008 i_lsu_req, i_lsu_wen  input  1 each  LSU request; 1 = write, 0 = read. Held with all LSU inputs stable until o_lsu_gnt.
REQ-009 i_lsu_addr, i_lsu_wdata  input  32 each  LSU address, write data.
REQ-010 i_lsu_wmask  input  4  LSU byte write mask.
REQ-011 o_lsu_gnt / o_lsu_rvalid  output  1 each  LSU accepted / LSU response (read data or write ack).
REQ-012 o_lsu_rdata  output  32  LSU read data.
REQ-013 o_mem_req, o_mem_wen  output  1 each  memory request, write flag.
REQ-014 o_mem_addr, o_mem_wdata  output  32 each; o_mem_wmask  output  4.
REQ-015 i_mem_gnt, i_mem_rvalid  input  1 each  memory accept; memory response.
REQ-016 i_mem_rdata  input  32  memory read data.
REQ-017 o_busy  output  1  high whenever state is not IDLE.
REQ-018 o_err  output  1  sticky protocol error flag.

Function
REQ-019 FSM states SHALL be IDLE, REQ, RESP; at most one memory transaction outstanding.
REQ-020 IDLE: if any request is present, SHALL select an owner, latch owner identity, go to REQ next cycle; otherwise stay IDLE.
REQ-021 Selection: only one requester present -> that requester; both present -> LSU, unless streak == MAX_LSU_STREAK, then IFU.
REQ-022 streak (4-bit) SHALL increment, saturating, when LSU is selected while i_ifu_req is high; SHALL clear when IFU is selected; SHALL be unchanged otherwise.
REQ-023 REQ: o_mem_req=1; o_mem_addr/wen/wdata/wmask SHALL be combinationally driven from the owner's inputs (IFU: wen=0, wdata=0, wmask=0).
REQ-024 REQ: o_<owner>_gnt = i_mem_gnt (same cycle); on i_mem_gnt go to RESP; otherwise stay in REQ holding the request.
REQ-025 RESP: o_mem_req=0; o_<owner>_rvalid = i_mem_rvalid (same cycle); on i_mem_rvalid go to IDLE.
REQ-026 o_ifu_rdata and o_lsu_rdata SHALL equal i_mem_rdata at all times; only rvalid qualifies them.
REQ-027 Non-owner gnt and rvalid SHALL be 0; outside REQ all gnt outputs SHALL be 0; outside RESP all rvalid outputs SHALL be 0.
REQ-028 Minimum latency: request at cycle T, gnt at T+1, rvalid at T+2; back-to-back grants SHALL be spaced by at least 3 cycles.
REQ-029 i_mem_rvalid while in IDLE or REQ SHALL set o_err and SHALL be otherwise ignored; o_err stays set until reset.
REQ-030 Requests dropped by a requester before gnt are a requester protocol violation; the arbiter SHALL continue the latched transaction unchanged.

Reset
REQ-031 i_rst high at a clock edge SHALL force state IDLE, streak=0, o_err=0, from any state including mid-transaction.
REQ-032 From that edge on, while in IDLE: o_mem_req, all gnt, all rvalid, o_busy SHALL be 0; an in-flight response arriving afterwards SHALL set o_err.
REQ-033 i_rst takes priority over all other inputs in the same cycle.

Verification
REQ-034 IFU only, addr 0x80000000, mem gnt immediately, rvalid next cycle with 0x00000413 -> o_ifu_gnt at T+1, o_ifu_rvalid=1 and o_ifu_rdata=0x00000413 at T+2, o_busy 0 at T+3.
REQ-035 Both request every cycle, mem always ready -> grant order LSU x4, IFU, LSU x4, IFU; streak returns to 0 after each IFU grant.
REQ-036 LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, i_mem_gnt delayed 3 cycles -> o_mem_req held 3+1 cycles with stable fields, o_lsu_gnt one cycle, then o_lsu_rvalid on mem ack.
REQ-037 i_mem_rvalid pulsed in IDLE -> o_err=1 and stays 1; no rvalid output asserted; cleared only by i_rst.
REQ-038 i_rst asserted during RESP -> next cycle IDLE, all outputs 0; late i_mem_rvalid then sets o_err.
REQ-039 IFU requests alone while LSU idle for 20 transactions -> all granted to IFU, streak stays 0, no o_err.
